floor_scheduler: RTL and testbench
==================================

# floor_scheduler

Elevator car scheduler for the four-floor design. It latches floor-call buttons into a pending-request vector and chooses the next direction with a SCAN policy (keep going while requests lie ahead, otherwise reverse). It sequences the motion datapath one floor at a time through a step handshake and holds the door open for a fixed time at each served floor. It publishes the current floor as the 3-bit stage code the display path uses (3'd4..3'd7 for floors 0..3).

## Interface
- DOOR_CYCLES, default 50_000_000: cycles door_open stays high per stop (≥1).
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- btn  in  4  floor-call buttons, btn[i] = floor i, level-sensitive.
- step_done  in  1  one-cycle pulse from motion datapath: requested one-floor step completed.
- step_req  out  1  request one-floor move; held until step_done.
- step_up  out  1  step direction (1 = up); stable while step_req high.
- door_open  out  1  door open / dwell active.
- pending  out  4  latched unserved requests.
- stage  out  3  {1'b1, cur_floor}.
- busy  out  1  high in any state other than IDLE.

## Operation
- Reset values: state IDLE, cur_floor 0, dir_up 1, pending 0, step_req 0, step_up 1, door_open 0, busy 0, stage 3'd4.
- Request capture: pending[i] sets on any cycle btn[i]=1. It clears only on entry to DOOR at floor i. If btn[cur_floor] is high during DOOR, pending is not set: the call is already served and the door timer reloads.
- States:
  - IDLE: if pending≠0, go to DECIDE.
  - DECIDE:
    - pending[cur_floor] → DOOR.
    - Else if a request exists in dir_up direction → STEP.
    - Else if a request exists in the opposite direction → toggle dir_up, then STEP.
    - Else → IDLE.
  - STEP: step_req=1, step_up=dir_up. On step_done: cur_floor ±1, drop step_req, go to CHECK.
  - CHECK: pending[cur_floor] → DOOR. Else re-evaluate as in DECIDE (same direction if requests remain ahead, else reverse, else IDLE).
  - DOOR: door_open=1; counter loaded DOOR_CYCLES−1 on entry, decrements to 0, then DECIDE.
- Direction is only chosen toward existing requests, so cur_floor never leaves 0..3. Floor arithmetic is 2-bit.
- step_done outside STEP is ignored.
- rst mid-step or mid-door returns immediately to reset values. The motion datapath sees step_req fall on the next cycle.

## Timing
- btn[i] high at cycle n → pending[i]=1 at n+1.
- From IDLE: pending set at n+1 → DECIDE at n+2 → step_req high at n+3. If the request is at cur_floor, door_open is high at n+3 instead.
- step_done at cycle m → cur_floor/stage updated and step_req=0 at m+1 (CHECK). Next step_req at m+2, or door_open at m+2.
- door_open high for exactly DOOR_CYCLES cycles per stop, extended by any reload.
- Outputs are registered; no combinational path from inputs to outputs.

## Configuration
- FLOOR_SCHED_SYNC_EN defined: btn passes through a 2-flop synchronizer before capture. Every btn-to-pending latency grows by 2 cycles (n → n+3).
- Undefined: btn is sampled directly, with latency as above.

## Structure
- Shared package floor_sched_pkg:
  - state enum (IDLE, DECIDE, STEP, CHECK, DOOR)
  - NUM_FLOORS=4
  - STAGE_BASE=3'd4
  - function floor→stage code.
- One sub-module, floor_sched_dir: combinational pick of next direction/stop from pending, cur_floor, dir_up. It is shared by DECIDE and CHECK.
- Door counter and request latch stay in the top module.

## Test plan
- Reset, then idle 10 cycles → stage=3'd4, pending=0, step_req=0, busy=0.
- btn=4'b1000 for one cycle from floor 0, with step_done returned 2 cycles after each step_req:
  - three up steps with step_up=1;
  - stage ends at 3'd7, door_open for DOOR_CYCLES (=4 in bench);
  - pending=0, then IDLE.
- At floor 1 moving up, pending={3,0}:
  - serves 3 first, then reverses with step_up=0 and serves 0;
  - stage sequence 5,6,7,6,5,4.
- btn[cur_floor] pulsed in IDLE at floor 2 → door_open at n+3, no step_req. Pulsed again mid-door → door_open extends to DOOR_CYCLES after the pulse.
- rst asserted while step_req=1 → next cycle step_req=0, stage=3'd4, pending=0. A stray step_done afterwards does not change stage.
- With FLOOR_SCHED_SYNC_EN → pending[i] rises 3 cycles after btn[i]. Without it → 1 cycle.

Source files
------------

// File: rtl/floor_sched_pkg.sv
// Shared types and constants for the four-floor car scheduler.
package floor_sched_pkg;

  localparam int unsigned NUM_FLOORS = 4;
  localparam logic [2:0]  STAGE_BASE = 3'd4;

  typedef logic [$clog2(NUM_FLOORS)-1:0] floor_t;

  typedef enum logic [2:0] {
    IDLE,
    DECIDE,
    STEP,
    CHECK,
    DOOR
  } state_t;

  function automatic logic [2:0] floor_to_stage(input floor_t f);
    return STAGE_BASE | {1'b0, f};
  endfunction

endpackage

// File: rtl/floor_sched_dir.sv
// SCAN direction pick: stop here, keep heading, reverse, or go idle.
module floor_sched_dir
  import floor_sched_pkg::*;
(
  input  logic [NUM_FLOORS-1:0] pending,
  input  floor_t                cur_floor,
  input  logic                  dir_up,
  output logic                  stop,
  output logic                  move,
  output logic                  next_up
);

  logic ahead_up;
  logic ahead_dn;

  always_comb begin
    ahead_up = 1'b0;
    ahead_dn = 1'b0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      if (pending[i] && (i > 32'(cur_floor))) ahead_up = 1'b1;
      if (pending[i] && (i < 32'(cur_floor))) ahead_dn = 1'b1;
    end
  end

  always_comb begin
    stop    = pending[cur_floor];
    move    = ahead_up | ahead_dn;
    next_up = dir_up;
    if (dir_up && !ahead_up && ahead_dn) next_up = 1'b0;
    if (!dir_up && !ahead_dn && ahead_up) next_up = 1'b1;
  end

endmodule

// File: rtl/floor_scheduler.sv
// Elevator car scheduler: request latch, SCAN FSM, step handshake, door timer.
// Define FLOOR_SCHED_SYNC_EN to pass btn through a 2-flop synchronizer.
module floor_scheduler
  import floor_sched_pkg::*;
#(
  parameter int unsigned DOOR_CYCLES = 50_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] btn,
  input  logic                  step_done,
  output logic                  step_req,
  output logic                  step_up,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending,
  output logic [2:0]            stage,
  output logic                  busy
);

  localparam int unsigned CW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [CW-1:0] DOOR_LOAD = CW'(DOOR_CYCLES - 1);

  state_t          state;
  floor_t          cur_floor;
  logic            dir_up;
  logic [CW-1:0]   door_cnt;
  logic [NUM_FLOORS-1:0] btn_s;

`ifdef FLOOR_SCHED_SYNC_EN
  logic [NUM_FLOORS-1:0] btn_q1;
  logic [NUM_FLOORS-1:0] btn_q2;

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_q1 <= '0;
      btn_q2 <= '0;
    end else begin
      btn_q1 <= btn;
      btn_q2 <= btn_q1;
    end
  end

  assign btn_s = btn_q2;
`else
  assign btn_s = btn;
`endif

  logic   stop;
  logic   move;
  logic   next_up;
  floor_t step_floor;
  logic [NUM_FLOORS-1:0] pending_nxt;
  logic   enter_door;

  floor_sched_dir u_dir (
    .pending   (pending),
    .cur_floor (cur_floor),
    .dir_up    (dir_up),
    .stop      (stop),
    .move      (move),
    .next_up   (next_up)
  );

  assign step_floor = dir_up ? cur_floor + floor_t'(1) : cur_floor - floor_t'(1);
  assign enter_door = ((state == DECIDE) || (state == CHECK)) && stop;

  // A press at the open door is absorbed; entering DOOR clears that floor.
  always_comb begin
    pending_nxt = pending | btn_s;
    if (state == DOOR) pending_nxt[cur_floor] = pending[cur_floor];
    if (enter_door) pending_nxt[cur_floor] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cur_floor <= '0;
      dir_up    <= 1'b1;
      pending   <= '0;
      step_req  <= 1'b0;
      step_up   <= 1'b1;
      door_open <= 1'b0;
      door_cnt  <= '0;
      busy      <= 1'b0;
      stage     <= STAGE_BASE;
    end else begin
      pending <= pending_nxt;
      unique case (state)
        IDLE: begin
          if (pending != '0) begin
            state <= DECIDE;
            busy  <= 1'b1;
          end
        end
        DECIDE, CHECK: begin
          if (stop) begin
            state     <= DOOR;
            door_open <= 1'b1;
            door_cnt  <= DOOR_LOAD;
          end else if (move) begin
            state    <= STEP;
            dir_up   <= next_up;
            step_up  <= next_up;
            step_req <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        STEP: begin
          if (step_done) begin
            cur_floor <= step_floor;
            stage     <= floor_to_stage(step_floor);
            step_req  <= 1'b0;
            state     <= CHECK;
          end
        end
        DOOR: begin
          if (btn_s[cur_floor]) begin
            door_cnt <= DOOR_LOAD;
          end else if (door_cnt == '0) begin
            door_open <= 1'b0;
            state     <= DECIDE;
          end else begin
            door_cnt <= door_cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_floor_scheduler.sv
// Directed self-checking bench for floor_scheduler (DOOR_CYCLES = 4).
module tb_floor_scheduler;

  localparam int unsigned D = 4;
`ifdef FLOOR_SCHED_SYNC_EN
  localparam int unsigned LAT = 3;
`else
  localparam int unsigned LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn = '0;
  logic       step_done = 1'b0;
  logic       step_req;
  logic       step_up;
  logic       door_open;
  logic [3:0] pending;
  logic [2:0] stage;
  logic       busy;

  int errors = 0;
  int checks = 0;

  floor_scheduler #(.DOOR_CYCLES(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn       (btn),
    .step_done (step_done),
    .step_req  (step_req),
    .step_up   (step_up),
    .door_open (door_open),
    .pending   (pending),
    .stage     (stage),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] mask);
    btn = mask;
    @(negedge clk);
    btn = '0;
  endtask

  // Wait for a step request, answer it two cycles later, check the new floor.
  task automatic do_step(input string tag, input logic up, input logic [2:0] stg);
    int n = 0;
    while (!step_req && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, ".req"}, {31'd0, step_req}, 32'd1);
    chk({tag, ".up"}, {31'd0, step_up}, {31'd0, up});
    cyc(2);
    step_done = 1'b1;
    @(negedge clk);
    step_done = 1'b0;
    chk({tag, ".req_drop"}, {31'd0, step_req}, 32'd0);
    chk({tag, ".stage"}, {29'd0, stage}, {29'd0, stg});
  endtask

  task automatic door_len(input string tag, input int unsigned exp);
    int n = 0;
    int w = 0;
    while (!door_open && w < 50) begin
      @(negedge clk);
      w++;
    end
    while (door_open && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk(tag, 32'(n), 32'(exp));
  endtask

  initial begin
    cyc(3);
    rst = 1'b0;
    cyc(10);
    chk("rst.stage", {29'd0, stage}, 32'd4);
    chk("rst.pending", {28'd0, pending}, 32'd0);
    chk("rst.step_req", {31'd0, step_req}, 32'd0);
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.door", {31'd0, door_open}, 32'd0);
    chk("rst.step_up", {31'd0, step_up}, 32'd1);

    // Call to floor 3 from floor 0.
    press(4'b1000);
    cyc(LAT - 1);
    chk("lat.pending", {28'd0, pending}, 32'h8);
    do_step("up1", 1'b1, 3'd5);
    do_step("up2", 1'b1, 3'd6);
    do_step("up3", 1'b1, 3'd7);
    door_len("door3", D);
    chk("door3.pending", {28'd0, pending}, 32'd0);
    cyc(3);
    chk("door3.idle", {31'd0, busy}, 32'd0);

    // Move to floor 1 with direction up: down to 0, then up to 1.
    press(4'b0001);
    do_step("dn1", 1'b0, 3'd6);
    do_step("dn2", 1'b0, 3'd5);
    do_step("dn3", 1'b0, 3'd4);
    door_len("door0", D);
    cyc(3);
    press(4'b0010);
    do_step("rev1", 1'b1, 3'd5);
    door_len("door1", D);
    cyc(3);
    chk("scan.start", {29'd0, stage}, 32'd5);

    // Calls at 3 and 0 from floor 1 heading up: serve 3 first, then 0.
    press(4'b1001);
    cyc(LAT - 1);
    chk("scan.pending", {28'd0, pending}, 32'h9);
    do_step("scan1", 1'b1, 3'd6);
    do_step("scan2", 1'b1, 3'd7);
    door_len("scan.door3", D);
    chk("scan.pend_after3", {28'd0, pending}, 32'h1);
    do_step("scan3", 1'b0, 3'd6);
    do_step("scan4", 1'b0, 3'd5);
    do_step("scan5", 1'b0, 3'd4);
    door_len("scan.door0", D);
    chk("scan.pend_end", {28'd0, pending}, 32'd0);
    cyc(3);

    // Go to floor 2, then press its own button while idle.
    press(4'b0100);
    do_step("to2a", 1'b1, 3'd5);
    do_step("to2b", 1'b1, 3'd6);
    door_len("door2", D);
    cyc(3);
    press(4'b0100);
    cyc(LAT);
    chk("here.door_early", {31'd0, door_open}, 32'd0);
    @(negedge clk);
    chk("here.door", {31'd0, door_open}, 32'd1);
    chk("here.no_step", {31'd0, step_req}, 32'd0);
    @(negedge clk);
    press(4'b0100);
    begin
      int n = 0;
      while (door_open && n < 200) begin
        chk("here.no_pend", {28'd0, pending}, 32'd0);
        n++;
        @(negedge clk);
      end
      chk("here.extend", 32'(n), 32'(D + LAT - 1));
    end
    cyc(3);
    chk("here.idle", {31'd0, busy}, 32'd0);
    chk("here.stage", {29'd0, stage}, 32'd6);

    // Reset in the middle of a step.
    press(4'b0001);
    begin
      int n = 0;
      while (!step_req && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk("mid.req", {31'd0, step_req}, 32'd1);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid.step_req", {31'd0, step_req}, 32'd0);
    chk("mid.stage", {29'd0, stage}, 32'd4);
    chk("mid.pending", {28'd0, pending}, 32'd0);
    chk("mid.busy", {31'd0, busy}, 32'd0);
    step_done = 1'b1;
    @(negedge clk);
    step_done = 1'b0;
    cyc(2);
    chk("stray.stage", {29'd0, stage}, 32'd4);
    chk("stray.step_req", {31'd0, step_req}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
